// File: rtl/ysyx_2022040010_mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface ysyx_2022040010_mdu_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      mdu_op;
    logic            mdu_32;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    // Requester side (EX stage)
    modport master (
        output in_valid, mdu_op, mdu_32, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result
    );

    // Unit side
    modport slave (
        input  in_valid, mdu_op, mdu_32, src1, src2, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/ysyx_2022040010_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier retiring UNROLL
// bits per cycle, restoring divider at one bit per cycle, valid/ready on both sides.
module ysyx_2022040010_mdu #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned UNROLL = 1
) (
    input logic                  clk,
    input logic                  rst,
    ysyx_2022040010_mdu_if.slave bus
);
    localparam int unsigned XW2     = 2 * XLEN;
    localparam int unsigned CNT_W   = $clog2(XLEN);
    localparam int unsigned MUL_N_X = XLEN / UNROLL;
    localparam int unsigned MUL_N_W = 32 / UNROLL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [XW2-1:0]   acc, acc_nx;
    logic [XW2-1:0]   mcand, mcand_nx;
    logic [XLEN-1:0]  mplier, mplier_nx;
    logic [XLEN-1:0]  rem, rem_nx;
    logic [XLEN-1:0]  quo, quo_nx;
    logic [XLEN-1:0]  dvsr, dvsr_nx;
    logic             is_mul, is_mul_nx;
    logic             is_rem, is_rem_nx;
    logic             sel_hi, sel_hi_nx;
    logic             word, word_nx;
    logic             neg, neg_nx;
    logic [XLEN-1:0]  result_q, result_nx;
    logic             in_ready_q;
    logic             out_valid_q;

    // Sign-extend the low word to XLEN
    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    // Request decode and operand preparation
    logic [7:0]      op;
    logic            op_ok;
    logic            s1_signed, s2_signed;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_w;
    logic            a_neg, b_neg;
    logic            req_mul, req_rem, req_hi;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        op        = bus.mdu_op;
        op_ok     = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
        s1_signed = op[7] | op[6] | op[5] | op[3] | op[1];
        s2_signed = op[7] | op[6] | op[3] | op[1];
        req_mul   = |op[7:4];
        req_rem   = op[1] | op[0];
        req_hi    = (|op[6:4]) & ~bus.mdu_32;

        if (bus.mdu_32) begin
            a_ext = s1_signed ? wext(bus.src1) : {{(XLEN-32){1'b0}}, bus.src1[31:0]};
            b_ext = s2_signed ? wext(bus.src2) : {{(XLEN-32){1'b0}}, bus.src2[31:0]};
            min_w = wext(XLEN'(32'h8000_0000));
        end else begin
            a_ext = bus.src1;
            b_ext = bus.src2;
            min_w = {1'b1, {(XLEN-1){1'b0}}};
        end

        a_neg = s1_signed & a_ext[XLEN-1];
        b_neg = s2_signed & b_ext[XLEN-1];
        a_mag = a_neg ? (XLEN'(0) - a_ext) : a_ext;
        b_mag = b_neg ? (XLEN'(0) - b_ext) : b_ext;

        div_zero = (|op[3:0]) && (b_ext == '0);
        div_ovf  = (op[3] | op[1]) && (a_ext == min_w) && (b_ext == '1);

        special_res = '0;
        if (!op_ok) begin
            special_res = '0;
        end else if (div_zero) begin
            special_res = req_rem ? (bus.mdu_32 ? wext(bus.src1) : bus.src1) : '1;
        end else if (div_ovf) begin
            special_res = req_rem ? '0 : min_w;
        end
    end

    // One iteration of multiplier and divider, plus final sign fix-up
    logic [XW2-1:0]  acc_step, mcand_step, prod_s;
    logic [XLEN-1:0] mplier_step, rem_step, quo_step;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] mul_res, div_raw, div_s, final_res;

    always_comb begin
        acc_step    = acc;
        mcand_step  = mcand;
        mplier_step = mplier;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            if (mplier_step[0]) begin
                acc_step = acc_step + mcand_step;
            end
            mcand_step  = mcand_step << 1;
            mplier_step = mplier_step >> 1;
        end

        trial = {rem, quo[XLEN-1]};
        if (trial >= {1'b0, dvsr}) begin
            rem_step = XLEN'(trial - {1'b0, dvsr});
            quo_step = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_step = trial[XLEN-1:0];
            quo_step = {quo[XLEN-2:0], 1'b0};
        end

        prod_s = neg ? (XW2'(0) - acc_step) : acc_step;
        if (sel_hi) begin
            mul_res = prod_s[XW2-1:XLEN];
        end else begin
            mul_res = word ? wext(prod_s[XLEN-1:0]) : prod_s[XLEN-1:0];
        end

        div_raw   = is_rem ? rem_step : quo_step;
        div_s     = neg ? (XLEN'(0) - div_raw) : div_raw;
        final_res = is_mul ? mul_res : (word ? wext(div_s) : div_s);
    end

    // Next-state and datapath register update
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        acc_nx    = acc;
        mcand_nx  = mcand;
        mplier_nx = mplier;
        rem_nx    = rem;
        quo_nx    = quo;
        dvsr_nx   = dvsr;
        is_mul_nx = is_mul;
        is_rem_nx = is_rem;
        sel_hi_nx = sel_hi;
        word_nx   = word;
        neg_nx    = neg;
        result_nx = result_q;

        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    is_mul_nx = req_mul;
                    is_rem_nx = req_rem;
                    sel_hi_nx = req_hi;
                    word_nx   = bus.mdu_32;
                    neg_nx    = req_rem ? a_neg : (a_neg ^ b_neg);
                    acc_nx    = '0;
                    mcand_nx  = {{XLEN{1'b0}}, a_mag};
                    mplier_nx = b_mag;
                    rem_nx    = '0;
                    quo_nx    = bus.mdu_32 ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
                    dvsr_nx   = b_mag;
                    if (!op_ok || div_zero || div_ovf) begin
                        result_nx = special_res;
                        state_nx  = DONE;
                    end else begin
                        state_nx = CALC;
                        if (req_mul) begin
                            cnt_nx = bus.mdu_32 ? CNT_W'(MUL_N_W - 1) : CNT_W'(MUL_N_X - 1);
                        end else begin
                            cnt_nx = bus.mdu_32 ? CNT_W'(31) : CNT_W'(XLEN - 1);
                        end
                    end
                end
            end
            CALC: begin
                acc_nx    = acc_step;
                mcand_nx  = mcand_step;
                mplier_nx = mplier_step;
                rem_nx    = rem_step;
                quo_nx    = quo_step;
                cnt_nx    = cnt - CNT_W'(1);
                if (cnt == '0) begin
                    result_nx = final_res;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // A redirect kills whatever is in flight and leaves the last result as is
        if (bus.flush) begin
            state_nx  = IDLE;
            result_nx = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            rem         <= '0;
            quo         <= '0;
            dvsr        <= '0;
            is_mul      <= 1'b0;
            is_rem      <= 1'b0;
            sel_hi      <= 1'b0;
            word        <= 1'b0;
            neg         <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            acc         <= acc_nx;
            mcand       <= mcand_nx;
            mplier      <= mplier_nx;
            rem         <= rem_nx;
            quo         <= quo_nx;
            dvsr        <= dvsr_nx;
            is_mul      <= is_mul_nx;
            is_rem      <= is_rem_nx;
            sel_hi      <= sel_hi_nx;
            word        <= word_nx;
            neg         <= neg_nx;
            result_q    <= result_nx;
            in_ready_q  <= (state_nx == IDLE);
            out_valid_q <= (state_nx == DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_ysyx_2022040010_mdu.sv
// Scoreboard bench for the RV64M multiply/divide unit: driver pushes model
// results on accept, monitor pops and compares on every presented output.
module tb_ysyx_2022040010_mdu;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned UNROLL = 1;

    localparam logic [7:0] OP_MUL    = 8'h80;
    localparam logic [7:0] OP_MULH   = 8'h40;
    localparam logic [7:0] OP_MULHSU = 8'h20;
    localparam logic [7:0] OP_MULHU  = 8'h10;
    localparam logic [7:0] OP_DIV    = 8'h08;
    localparam logic [7:0] OP_DIVU   = 8'h04;
    localparam logic [7:0] OP_REM    = 8'h02;
    localparam logic [7:0] OP_REMU   = 8'h01;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc_edge;
        int          hold;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    exp_t exp_q[$];

    ysyx_2022040010_mdu_if #(.XLEN(XLEN)) bus ();

    ysyx_2022040010_mdu #(.XLEN(XLEN), .UNROLL(UNROLL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural result of one RV64M operation
    function automatic logic [63:0] ref_model(input logic [7:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0] wa, wb, p;
        logic [31:0]  a32, b32, r32;
        logic [63:0]  r;
        a32 = a[31:0];
        b32 = b[31:0];
        r32 = '0;
        r   = '0;
        wa  = '0;
        wb  = '0;
        p   = '0;
        if (!$onehot(op)) return 64'd0;
        if (w) begin
            case (op)
                OP_DIV:  if (b32 == 0) r32 = '1;
                         else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                         else r32 = $signed(a32) / $signed(b32);
                OP_DIVU: r32 = (b32 == 0) ? '1 : a32 / b32;
                OP_REM:  if (b32 == 0) r32 = a32;
                         else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
                         else r32 = $signed(a32) % $signed(b32);
                OP_REMU: r32 = (b32 == 0) ? a32 : a32 % b32;
                default: r32 = a32 * b32;
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (op)
            OP_MUL:    r = a * b;
            OP_MULH:   begin wa = {{64{a[63]}}, a}; wb = {{64{b[63]}}, b}; p = wa * wb; r = p[127:64]; end
            OP_MULHSU: begin wa = {{64{a[63]}}, a}; wb = {64'd0, b};       p = wa * wb; r = p[127:64]; end
            OP_MULHU:  begin wa = {64'd0, a};       wb = {64'd0, b};       p = wa * wb; r = p[127:64]; end
            OP_DIV:    if (b == 0) r = ONES;
                       else if (a == MIN && b == ONES) r = MIN;
                       else r = $signed(a) / $signed(b);
            OP_DIVU:   r = (b == 0) ? ONES : a / b;
            OP_REM:    if (b == 0) r = a;
                       else if (a == MIN && b == ONES) r = '0;
                       else r = $signed(a) % $signed(b);
            OP_REMU:   r = (b == 0) ? a : a % b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    // Clock edges from accept (inclusive) to first out_valid
    function automatic int exp_lat(input logic [7:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        int  width;
        bit  bz, ovf;
        width = w ? 32 : 64;
        if (!$onehot(op)) return 1;
        if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return width / UNROLL + 1;
        bz  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf = (op == OP_DIV || op == OP_REM) &&
              (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN && b == ONES));
        if (bz || ovf) return 1;
        return width + 1;
    endfunction

    task automatic send(input logic [7:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input bit track, input int hold);
        int   waitc;
        exp_t e;
        waitc = 0;
        @(negedge clk);
        while (!bus.in_ready && waitc < 400) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.mdu_op   = op;
        bus.mdu_32   = w;
        bus.src1     = a;
        bus.src2     = b;
        if (track) begin
            e.res      = ref_model(op, w, a, b);
            e.lat      = exp_lat(op, w, a, b);
            e.acc_edge = cyc + 1;
            e.hold     = hold;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return ONES;
            2:       return MIN;
            3:       return 64'h0000_0000_8000_0000;
            4:       return 64'($urandom_range(0, 20));
            5:       return 64'd0 - 64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: compare each presented result against the head of the scoreboard
    initial begin : monitor
        int   held;
        bit   seen;
        exp_t e;
        held = 0;
        seen = 1'b0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
                seen = 1'b0;
                bus.out_ready = 1'b0;
            end else if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                    bus.out_ready = 1'b1;
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        seen = 1'b1;
                        check("latency", 64'(cyc - e.acc_edge + 1), 64'(e.lat));
                    end
                    check("result", bus.result, e.res);
                    check("in_ready_while_done", 64'(bus.in_ready), 64'd0);
                    if (held < e.hold) begin
                        held++;
                        bus.out_ready = 1'b0;
                    end else begin
                        bus.out_ready = 1'b1;
                        void'(exp_q.pop_front());
                        held = 0;
                        seen = 1'b0;
                    end
                end
            end else begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Stimulus
    initial begin : driver
        int         waitc;
        logic [7:0] op;
        bus.in_valid = 1'b0;
        bus.mdu_op   = '0;
        bus.mdu_32   = 1'b0;
        bus.src1     = '0;
        bus.src2     = '0;
        bus.flush    = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", bus.result, 64'd0);
        rst = 1'b0;

        // Directed cases
        send(OP_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 0);
        send(OP_MULHU,  1'b0, ONES, ONES, 1'b1, 0);
        send(OP_MULH,   1'b0, ONES, ONES, 1'b1, 0);
        send(OP_MULHSU, 1'b0, ONES, 64'd5, 1'b1, 0);
        send(OP_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 0);
        send(OP_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 0);
        send(OP_DIVU,   1'b0, 64'd5, 64'd0, 1'b1, 0);
        send(OP_REM,    1'b0, 64'd5, 64'd0, 1'b1, 0);
        send(OP_REMU,   1'b0, 64'd5, 64'd0, 1'b1, 0);
        send(OP_DIV,    1'b0, MIN, ONES, 1'b1, 0);
        send(OP_REM,    1'b0, MIN, ONES, 1'b1, 0);
        send(OP_DIV,    1'b1, 64'h0000_0000_8000_0000, ONES, 1'b1, 0);
        send(OP_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 1'b1, 0);
        send(OP_MULH,   1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0003, 1'b1, 0);
        send(OP_REMU,   1'b1, 64'hDEAD_BEEF_8000_0007, 64'h0000_0000_0000_0000, 1'b1, 0);
        send(8'h00,     1'b0, 64'd9, 64'd3, 1'b1, 0);
        send(8'h03,     1'b0, 64'd9, 64'd3, 1'b1, 0);

        // Back-pressure: consumer holds out_ready low for 10 cycles
        send(OP_MUL, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd3, 1'b1, 10);

        // Randomised traffic
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(0, 255));
            else op = 8'(1 << $urandom_range(0, 7));
            send(op, 1'($urandom_range(0, 1)), rand_operand(), rand_operand(), 1'b1,
                 $urandom_range(0, 2));
        end

        // Flush mid-CALC: unit returns to IDLE and never presents a result
        send(OP_DIV, 1'b0, 64'd1000, 64'd7, 1'b0, 0);
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_calc_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_calc_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (70) @(negedge clk);

        // Flush together with a request in IDLE drops the request
        bus.in_valid = 1'b1;
        bus.mdu_op   = OP_DIVU;
        bus.mdu_32   = 1'b0;
        bus.src1     = 64'd10;
        bus.src2     = 64'd0;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_idle_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-CALC aborts at once
        send(OP_MULHU, 1'b0, ONES, 64'd12345, 1'b1, 0);
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_result", bus.result, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Unit still works after the abort
        send(OP_REMU, 1'b0, 64'd1000, 64'd7, 1'b1, 0);

        waitc = 0;
        while (exp_q.size() != 0 && waitc < 1000) begin
            @(negedge clk);
            waitc++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global time bound
    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
